// File: rtl/display_sched_pkg.sv
// rtl/display_sched_pkg.sv - shared types, default widths and gamma helper for the display scan scheduler
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int CW_DEF     = 24;
  localparam int BW_DEF     = 4;
  localparam int DIGITS_DEF = 4;

  // Perceptual curve: (r*r + 2^BW - 1) >> BW keeps 0 -> 0 and full scale -> full scale.
  function automatic logic [BW_DEF-1:0] gamma(input logic [BW_DEF-1:0] r);
    logic [2*BW_DEF-1:0] sq;
    sq = {{BW_DEF{1'b0}}, r} * {{BW_DEF{1'b0}}, r} + (2*BW_DEF)'((2 ** BW_DEF) - 1);
    return sq[2*BW_DEF-1:BW_DEF];
  endfunction

endpackage

// File: rtl/display_sched_if.sv
// rtl/display_sched_if.sv - timer configuration/run bus between scheduler (master) and timer (slave)
interface display_sched_if
  import display_pkg::*;
#(
  parameter int CW = CW_DEF
);

  logic [CW-1:0] tmr_count;
  logic          flag;
  logic [CW-1:0] tmr_period;
  logic [CW-1:0] tmr_compare;
  logic          tmr_run;

  modport master (
    input  tmr_count,
    input  flag,
    output tmr_period,
    output tmr_compare,
    output tmr_run
  );

  modport slave (
    output tmr_count,
    output flag,
    input  tmr_period,
    input  tmr_compare,
    input  tmr_run
  );

endinterface

// File: rtl/display_sched_cfg_calc.sv
// rtl/display_sched_cfg_calc.sv - LOAD-stage period clamp and compare compute (gamma under DISPLAY_SCHED_GAMMA_EN)
module sched_cfg_calc
  import display_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int BW = BW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] slot_period,
  input  logic [BW-1:0] raw,
  output logic [CW-1:0] period,
  output logic [CW-1:0] compare
);

  logic [CW-1:0]    per_c;
  logic [BW-1:0]    b;
  logic [CW+BW-1:0] prod;

  // Clamp a zero period to 1, map raw brightness, and scale the period by b / 2^BW.
  always_comb begin
    per_c = (slot_period == '0) ? CW'(1) : slot_period;
`ifdef DISPLAY_SCHED_GAMMA_EN
    b = gamma(raw);
`else
    b = raw;
`endif
    prod = (CW+BW)'(per_c) * (CW+BW)'(b);
  end

  // Shadow registers: config is captured only during LOAD and held for the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period  <= '0;
      compare <= '0;
    end else if (load) begin
      period  <= per_c;
      compare <= prod[CW+BW-1:BW];
    end
  end

endmodule

// File: rtl/display_sched.sv
// rtl/display_sched.sv - multiplexed 7-segment scan scheduler with per-digit PWM (option: DISPLAY_SCHED_GAMMA_EN)
module display_sched
  import display_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int CW     = CW_DEF,
  parameter int BW     = BW_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [CW-1:0]              slot_period,
  input  logic [DIGITS*BW-1:0]       bright,
  display_sched_if.master            tmr,
  output logic [$clog2(DIGITS)-1:0]  digit_sel,
  output logic [DIGITS-1:0]          an_n,
  output logic                       frame_tick
);

  localparam int DSW = $clog2(DIGITS);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_LOAD = 2'(LOAD);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_GAP  = 2'(GAP);

  localparam logic [DSW-1:0] LAST_DIGIT = DSW'(DIGITS - 1);

  logic [1:0]    state;
  logic          load;
  logic [BW-1:0] raw;

  assign load = (state == ST_LOAD);
  assign raw  = bright[digit_sel*BW +: BW];

  sched_cfg_calc #(
    .CW(CW),
    .BW(BW)
  ) u_cfg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .slot_period(slot_period),
    .raw        (raw),
    .period     (tmr.tmr_period),
    .compare    (tmr.tmr_compare)
  );

  // Slot sequencer and digit counter; dropping en aborts to IDLE and rewinds to digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      digit_sel <= '0;
    end else if (!en) begin
      state     <= ST_IDLE;
      digit_sel <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_LOAD;
        ST_LOAD: state <= ST_RUN;
        ST_RUN:  if (tmr.tmr_count == tmr.tmr_period) state <= ST_GAP;
        default: begin
          state     <= ST_LOAD;
          digit_sel <= (digit_sel == LAST_DIGIT) ? '0 : digit_sel + 1'b1;
        end
      endcase
    end
  end

  // Timer runs only in RUN; frame_tick marks the GAP that wraps the digit counter.
  always_comb begin
    tmr.tmr_run = (state == ST_RUN);
    frame_tick  = (state == ST_GAP) && en && (digit_sel == LAST_DIGIT);
  end

  // Only the selected anode may go low, and only while the timer flag is set in RUN.
  always_comb begin
    an_n = '1;
    if (state == ST_RUN) an_n[digit_sel] = ~tmr.flag;
  end

endmodule
